// File: rtl/parking_request_encoder.sv
// parking_request_encoder: synchronizes and debounces the parking sensors,
// queues enter/exit requests and issues one-cycle commands with ack timeout.
module parking_request_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned ACK_TIMEOUT     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter_btn,
  input  logic       exit_btn,
  input  logic [1:0] exit_place,
  input  logic [3:0] occupancy,
  input  logic       door_open_pulse,
  output logic [3:0] cmd,
  output logic       busy,
  output logic       done,
  output logic       rejected,
  output logic       dropped
);

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK
  } state_t;

  state_t     r_state;
  logic       r_en_s1;
  logic       r_en_s2;
  logic       r_ex_s1;
  logic       r_ex_s2;
  logic [1:0] r_pl_s1;
  logic [1:0] r_pl_s2;
  logic       r_en_db;
  logic       r_ex_db;
  logic [7:0] r_en_cnt;
  logic [7:0] r_ex_cnt;
  logic       r_en_pend;
  logic       r_ex_pend;
  logic [1:0] r_place;
  logic [7:0] r_timer;

  logic       w_en_flip;
  logic       w_ex_flip;
  logic       w_en_rise;
  logic       w_ex_rise;
  logic       w_sel_ex;
  logic       w_sel_en;
  logic       w_ex_ok;
  logic       w_en_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_en_s1 <= 1'b0;
      r_en_s2 <= 1'b0;
      r_ex_s1 <= 1'b0;
      r_ex_s2 <= 1'b0;
      r_pl_s1 <= 2'b00;
      r_pl_s2 <= 2'b00;
    end else begin
      r_en_s1 <= enter_btn;
      r_en_s2 <= r_en_s1;
      r_ex_s1 <= exit_btn;
      r_ex_s2 <= r_ex_s1;
      r_pl_s1 <= exit_place;
      r_pl_s2 <= r_pl_s1;
    end
  end

  // A level flips on the Nth consecutive mismatching edge.
  assign w_en_flip = (r_en_s2 != r_en_db) && (r_en_cnt == DB_LAST);
  assign w_ex_flip = (r_ex_s2 != r_ex_db) && (r_ex_cnt == DB_LAST);
  assign w_en_rise = w_en_flip && r_en_s2;
  assign w_ex_rise = w_ex_flip && r_ex_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_en_db  <= 1'b0;
      r_ex_db  <= 1'b0;
      r_en_cnt <= 8'd0;
      r_ex_cnt <= 8'd0;
    end else begin
      if (r_en_s2 == r_en_db) begin
        r_en_cnt <= 8'd0;
      end else if (w_en_flip) begin
        r_en_cnt <= 8'd0;
        r_en_db  <= r_en_s2;
      end else begin
        r_en_cnt <= r_en_cnt + 8'd1;
      end
      if (r_ex_s2 == r_ex_db) begin
        r_ex_cnt <= 8'd0;
      end else if (w_ex_flip) begin
        r_ex_cnt <= 8'd0;
        r_ex_db  <= r_ex_s2;
      end else begin
        r_ex_cnt <= r_ex_cnt + 8'd1;
      end
    end
  end

  assign w_sel_ex = (r_state == IDLE) && r_ex_pend;
  assign w_sel_en = (r_state == IDLE) && !r_ex_pend && r_en_pend;
  assign w_ex_ok  = occupancy[r_place];
  assign w_en_ok  = (occupancy != 4'b1111);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_en_pend <= 1'b0;
      r_ex_pend <= 1'b0;
      r_place   <= 2'b00;
      dropped   <= 1'b0;
    end else begin
      r_en_pend <= (r_en_pend & ~w_sel_en) | (w_en_rise & ~r_en_pend);
      r_ex_pend <= (r_ex_pend & ~w_sel_ex) | (w_ex_rise & ~r_ex_pend);
      if (w_ex_rise && !r_ex_pend) begin
        r_place <= r_pl_s2;
      end
      dropped <= (w_en_rise & r_en_pend) | (w_ex_rise & r_ex_pend);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_timer  <= 8'd0;
      cmd      <= 4'b0000;
      busy     <= 1'b0;
      done     <= 1'b0;
      rejected <= 1'b0;
    end else begin
      done     <= 1'b0;
      rejected <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_sel_ex) begin
            if (w_ex_ok) begin
              cmd     <= {2'b01, r_place};
              busy    <= 1'b1;
              r_state <= ISSUE;
            end else begin
              rejected <= 1'b1;
            end
          end else if (w_sel_en) begin
            if (w_en_ok) begin
              cmd     <= 4'b1000;
              busy    <= 1'b1;
              r_state <= ISSUE;
            end else begin
              rejected <= 1'b1;
            end
          end
        end
        ISSUE: begin
          cmd     <= 4'b0000;
          r_timer <= 8'd0;
          r_state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (door_open_pulse) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= IDLE;
          end else if (r_timer == TO_LAST) begin
            rejected <= 1'b1;
            busy     <= 1'b0;
            r_state  <= IDLE;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        default: begin
          cmd     <= 4'b0000;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/parking_request_encoder.md
PARKING_REQUEST_ENCODER -- requirements
Module: parking_request_encoder

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required before a button level is accepted (legal range 1..255).
REQ-002 The block SHALL have parameter ACK_TIMEOUT, default 8: maximum cycles spent in WAIT_ACK (legal range 1..255).
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enter_btn  input  1  raw, asynchronous entry sensor.
REQ-006 exit_btn  input  1  raw, asynchronous exit sensor.
REQ-007 exit_place  input  2  raw spot index of the exiting car.
REQ-008 occupancy  input  4  parking-spot occupancy from the parking FSM; bit i = spot i taken.
REQ-009 door_open_pulse  input  1  acknowledge from the parking FSM; high for one cycle after an accepted state change.
REQ-010 cmd  output  4  command word to the parking FSM: {enter, exit, place[1:0]}; idle = 4'b0000.
REQ-011 busy  output  1  high while the FSM is not IDLE.
REQ-012 done  output  1  one-cycle pulse: command acknowledged.
REQ-013 rejected  output  1  one-cycle pulse: request filtered or ack timed out.
REQ-014 dropped  output  1  one-cycle pulse: new request lost because the same type was already pending.

Function
REQ-015 enter_btn, exit_btn and exit_place SHALL each pass through a 2-flop synchronizer before any other use.
REQ-016 Each synchronized button SHALL have a debounced level that changes on the edge where the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive edges; any mismatch-free cycle clears that counter.
REQ-017 A debounced rising edge on enter SHALL set enter_pend; a debounced rising edge on exit SHALL set exit_pend and latch the synchronized exit_place into pend_place on the same edge.
REQ-018 A debounced rising edge while the same-type pend flag is already set SHALL be discarded (pend_place unchanged) and SHALL pulse dropped for one cycle.
REQ-019 Control FSM states SHALL be IDLE, ISSUE, WAIT_ACK.
REQ-020 IDLE: if exit_pend, select exit; else if enter_pend, select enter; exit SHALL have priority when both are pending.
REQ-021 Filter in IDLE: an enter while occupancy == 4'b1111, or an exit while occupancy[pend_place] == 0, SHALL clear that pend flag, pulse rejected and remain in IDLE without driving cmd.
REQ-022 IDLE with a valid selection SHALL, on the next edge, clear the selected pend flag, drive cmd (enter: 4'b1000; exit: {2'b01, pend_place}) and enter ISSUE.
REQ-023 cmd SHALL be non-zero for exactly one cycle (ISSUE); on the following edge cmd returns to 4'b0000, the timer clears and the FSM enters WAIT_ACK.
REQ-024 WAIT_ACK: door_open_pulse sampled high SHALL pulse done and return to IDLE on that edge; otherwise the timer increments, and after ACK_TIMEOUT edges without ack the FSM SHALL pulse rejected and return to IDLE.
REQ-025 door_open_pulse outside WAIT_ACK SHALL be ignored.
REQ-026 Requests arriving during ISSUE/WAIT_ACK SHALL be held pending and served from IDLE afterwards; at most one command is outstanding.
REQ-027 done, rejected and dropped SHALL never be high for more than one consecutive cycle per event; rejected and done SHALL never be high in the same cycle.

Reset
REQ-028 On reset: FSM = IDLE, cmd = 4'b0000, busy = done = rejected = dropped = 0, pend flags, pend_place, timer, debounce counters, synchronizers and debounced levels = 0.
REQ-029 Reset asserted mid-ISSUE or mid-WAIT_ACK SHALL abandon the command with no done/rejected pulse; cmd is 4'b0000 in the cycle after the reset edge.
REQ-030 A button held high through reset release SHALL be seen as a new rising edge once debounced.

Verification
REQ-031 occupancy = 0000, enter_btn high steadily -> cmd = 1000 for exactly one cycle after 2 + 4 + 1 edges, ack one cycle later -> done pulse, busy low.
REQ-032 occupancy = 0101, exit_place = 10, exit_btn high -> cmd = 0110 one cycle; exit_place = 01 instead -> no cmd, rejected pulse.
REQ-033 Enter and exit debounced on the same edge, occupancy = 0001, exit_place = 00 -> cmd = 0100 first, then after done cmd = 1000.
REQ-034 Glitch: enter_btn high for 3 cycles, then low -> no cmd, no pulses.
REQ-035 Command issued, door_open_pulse held low -> rejected pulse exactly 8 edges after entering WAIT_ACK, FSM IDLE.
REQ-036 Second exit edge while exit_pend set -> dropped pulse, pend_place keeps first value; reset during WAIT_ACK -> cmd 0000, no done/rejected.
